branch_pc_unit: RTL and testbench
=================================

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: Imm_in  input  32  sign-extended B-type branch offset from the immediate generator; bit 0 always 0.
REQ-005 Port: Branch  input  1  current instruction is a conditional branch (opcode 1100011).
REQ-006 Port: Funct3  input  3  branch condition select.
REQ-007 Port: Rs1_data  input  32  first compare operand.
REQ-008 Port: Rs2_data  input  32  second compare operand.
REQ-009 Port: Stall  input  1  hold PC this cycle.
REQ-010 Port: Trap_ack  input  1  trap handler acknowledges a misaligned-target trap.
REQ-011 Port: PC_out  output  32  PC of the current instruction (registered).
REQ-012 Port: Flush  output  1  registered one-cycle pulse after a taken branch.
REQ-013 Port: Trap  output  1  high while in TRAP state.
REQ-014 Port: Trap_pc  output  32  faulting branch target, valid while Trap=1.
REQ-015 Port: Taken_count  output  16  saturating count of taken branches.

Function
REQ-016 Condition by Funct3 SHALL be: 000 BEQ (equal); 001 BNE (not equal); 100 BLT (signed <); 101 BGE (signed >=); 110 BLTU (unsigned <); 111 BGEU (unsigned >=); 010 and 011 never taken.
REQ-017 Taken SHALL be Branch AND the condition; when Branch=0, Funct3 and operands are ignored.
REQ-018 Target SHALL be PC_out + Imm_in, modulo 2^32 (wrap, no overflow flag); sequential PC SHALL be PC_out + 4, modulo 2^32.
REQ-019 FSM SHALL have two states: RUN and TRAP.
REQ-020 In RUN with Stall=1, PC_out, Flush, Taken_count SHALL hold, Flush SHALL be 0, and no branch SHALL be evaluated.
REQ-021 In RUN with Stall=0 and not taken, PC_out SHALL load PC_out+4 at the next edge.
REQ-022 In RUN with Stall=0, taken, and target[1]=0, PC_out SHALL load the target, Flush SHALL be 1 for exactly the next cycle, and Taken_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-023 In RUN with Stall=0, taken, and target[1]=1, the FSM SHALL go to TRAP, Trap_pc SHALL load the target, PC_out SHALL hold, Flush SHALL stay 0, and Taken_count SHALL not change.
REQ-024 In TRAP, Trap SHALL be 1, and Stall, Branch, and operands SHALL be ignored.
REQ-025 In TRAP with Trap_ack=1, the FSM SHALL return to RUN and PC_out SHALL load PC_out+4 at that edge; Trap SHALL be 0 from the next cycle.
REQ-026 Trap_ack in RUN SHALL have no effect.
REQ-027 Decision-to-PC latency SHALL be one clock; all outputs SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-028 When reset=1 at a rising edge, PC_out SHALL become RESET_PC; Flush, Trap, Taken_count, and Trap_pc SHALL become 0; and the FSM SHALL be in RUN.
REQ-029 Reset SHALL override Stall, Trap_ack, and any pending branch, including reset asserted while in TRAP.

Verification
REQ-030 Reset, then 3 cycles with Branch=0 and Stall=0 -> PC_out 0x0, 0x4, 0x8, 0xC; Flush=0.
REQ-031 PC_out=0x100, Branch=1, Funct3=000, Rs1=Rs2=5, Imm_in=0xFFFFFFF0 -> PC_out=0xF0, Flush=1 for one cycle, Taken_count=1.
REQ-032 Funct3=100, Rs1=0xFFFFFFFF, Rs2=1 -> taken; same operands with Funct3=110 -> not taken, PC_out+4.
REQ-033 PC_out=0x200, taken BNE, Imm_in=0x2 -> Trap=1, Trap_pc=0x202, PC_out held at 0x200 for 3 cycles; Trap_ack=1 -> PC_out=0x204, Trap=0.
REQ-034 Taken branch with Stall=1 -> PC_out unchanged, Flush=0; PC_out=0xFFFFFFFC with no branch -> PC_out=0x0 (wrap).
REQ-035 Taken_count preset to 0xFFFF via 65535 taken branches, then one more taken branch -> count stays 0xFFFF; reset asserted in TRAP -> PC_out=RESET_PC, Trap=0.

Source files
------------

// File: rtl/branch_pc_unit_if.sv
// Instruction-side bus between the branch/PC unit and the surrounding pipeline.
interface branch_pc_unit_if;
  logic [31:0] Imm_in;
  logic        Branch;
  logic [2:0]  Funct3;
  logic [31:0] Rs1_data;
  logic [31:0] Rs2_data;
  logic        Stall;
  logic        Trap_ack;
  logic [31:0] PC_out;
  logic        Flush;
  logic        Trap;
  logic [31:0] Trap_pc;
  logic [15:0] Taken_count;

  // Pipeline side: drives decode/operand info, observes PC state.
  modport master (
    output Imm_in, Branch, Funct3, Rs1_data, Rs2_data, Stall, Trap_ack,
    input  PC_out, Flush, Trap, Trap_pc, Taken_count
  );

  // PC unit side.
  modport slave (
    input  Imm_in, Branch, Funct3, Rs1_data, Rs2_data, Stall, Trap_ack,
    output PC_out, Flush, Trap, Trap_pc, Taken_count
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Branch resolution and PC sequencing with misaligned-target trap handling.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  branch_pc_unit_if.slave  bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;

  logic              cond_c;
  logic              taken_c;
  logic [XLEN-1:0]   target_c;
  logic [XLEN-1:0]   seq_c;

  // Branch condition decode.
  always_comb begin
    cond_c = 1'b0;
    unique case (bus.Funct3)
      3'b000:  cond_c = (bus.Rs1_data == bus.Rs2_data);
      3'b001:  cond_c = (bus.Rs1_data != bus.Rs2_data);
      3'b100:  cond_c = ($signed(bus.Rs1_data) <  $signed(bus.Rs2_data));
      3'b101:  cond_c = ($signed(bus.Rs1_data) >= $signed(bus.Rs2_data));
      3'b110:  cond_c = (bus.Rs1_data <  bus.Rs2_data);
      3'b111:  cond_c = (bus.Rs1_data >= bus.Rs2_data);
      default: cond_c = 1'b0;
    endcase
  end

  assign taken_c  = bus.Branch & cond_c;
  assign target_c = pc_q + bus.Imm_in;
  assign seq_c    = pc_q + XLEN'(4);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      trap_pc_q <= '0;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_pc_q <= trap_pc_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
    end
  end

  // Next-state and next-value logic; Flush only pulses after a taken, aligned branch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    cnt_d     = cnt_q;
    flush_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!bus.Stall) begin
          if (taken_c) begin
            if (target_c[1]) begin
              state_d   = TRAP;
              trap_pc_d = target_c;
            end else begin
              pc_d    = target_c;
              flush_d = 1'b1;
              if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            pc_d = seq_c;
          end
        end
      end
      TRAP: begin
        if (bus.Trap_ack) begin
          state_d = RUN;
          pc_d    = seq_c;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.PC_out      = pc_q;
  assign bus.Flush       = flush_q;
  assign bus.Trap        = (state_q == TRAP);
  assign bus.Trap_pc     = trap_pc_q;
  assign bus.Taken_count = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit.
module tb_branch_pc_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  branch_pc_unit_if bus ();

  branch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    bus.Branch   = br;
    bus.Funct3   = f3;
    bus.Rs1_data = a;
    bus.Rs2_data = b;
    bus.Imm_in   = imm;
  endtask

  task automatic seq_only;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.Stall    = 1'b0;
    bus.Trap_ack = 1'b0;
    seq_only();
    reset = 1'b1;
    tick();
    tick();
    check("rst_pc", bus.PC_out, 32'h0);
    check("rst_flush", 32'(bus.Flush), 32'h0);
    check("rst_trap", 32'(bus.Trap), 32'h0);
    check("rst_cnt", 32'(bus.Taken_count), 32'h0);
    check("rst_trap_pc", bus.Trap_pc, 32'h0);
    reset = 1'b0;

    // Sequential fetch.
    tick(); check("seq_4", bus.PC_out, 32'h4);
    tick(); check("seq_8", bus.PC_out, 32'h8);
    tick(); check("seq_c", bus.PC_out, 32'hC);
    check("seq_flush", 32'(bus.Flush), 32'h0);

    // BEQ forward to 0x100.
    drive(1'b1, 3'b000, 32'h0, 32'h0, 32'h0000_00F4);
    tick(); check("beq_fwd_pc", bus.PC_out, 32'h100);
    check("beq_fwd_flush", 32'(bus.Flush), 32'h1);
    check("beq_fwd_cnt", 32'(bus.Taken_count), 32'h1);

    // BEQ backward from 0x100 by -16.
    drive(1'b1, 3'b000, 32'd5, 32'd5, 32'hFFFF_FFF0);
    tick(); check("beq_back_pc", bus.PC_out, 32'hF0);
    check("beq_back_flush", 32'(bus.Flush), 32'h1);
    check("beq_back_cnt", 32'(bus.Taken_count), 32'h2);
    seq_only();
    tick(); check("flush_drop", 32'(bus.Flush), 32'h0);
    check("after_back_pc", bus.PC_out, 32'hF4);

    // Signed vs unsigned compares with -1 vs 1.
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h8);
    tick(); check("blt_pc", bus.PC_out, 32'hFC);
    check("blt_cnt", 32'(bus.Taken_count), 32'h3);
    drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h8);
    tick(); check("bltu_pc", bus.PC_out, 32'h100);
    check("bltu_flush", 32'(bus.Flush), 32'h0);
    check("bltu_cnt", 32'(bus.Taken_count), 32'h3);
    drive(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h8);
    tick(); check("bge_pc", bus.PC_out, 32'h104);
    drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h10);
    tick(); check("bgeu_pc", bus.PC_out, 32'h114);
    check("bgeu_cnt", 32'(bus.Taken_count), 32'h4);
    drive(1'b1, 3'b001, 32'd7, 32'd7, 32'h10);
    tick(); check("bne_eq_pc", bus.PC_out, 32'h118);
    drive(1'b1, 3'b010, 32'd7, 32'd7, 32'h10);
    tick(); check("f3_010_pc", bus.PC_out, 32'h11C);
    drive(1'b1, 3'b011, 32'd7, 32'd8, 32'h10);
    tick(); check("f3_011_pc", bus.PC_out, 32'h120);
    drive(1'b0, 3'b000, 32'd7, 32'd7, 32'h10);
    tick(); check("nobranch_pc", bus.PC_out, 32'h124);

    // Jump to 0x200, then misaligned BNE target.
    drive(1'b1, 3'b000, 32'd0, 32'd0, 32'h0000_00DC);
    tick(); check("to_200_pc", bus.PC_out, 32'h200);
    check("to_200_cnt", 32'(bus.Taken_count), 32'h5);
    drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h2);
    tick(); check("trap_on", 32'(bus.Trap), 32'h1);
    check("trap_pc", bus.Trap_pc, 32'h202);
    check("trap_flush", 32'(bus.Flush), 32'h0);
    check("trap_cnt", 32'(bus.Taken_count), 32'h5);
    for (int i = 0; i < 3; i++) begin
      bus.Stall = (i == 1);
      drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h40);
      tick();
      check("trap_hold_pc", bus.PC_out, 32'h200);
      check("trap_hold", 32'(bus.Trap), 32'h1);
    end
    check("trap_hold_cnt", 32'(bus.Taken_count), 32'h5);
    bus.Stall    = 1'b0;
    bus.Trap_ack = 1'b1;
    tick(); check("ack_pc", bus.PC_out, 32'h204);
    check("ack_trap", 32'(bus.Trap), 32'h0);
    seq_only();
    tick(); check("ack_in_run_pc", bus.PC_out, 32'h208);
    check("ack_in_run_trap", 32'(bus.Trap), 32'h0);
    bus.Trap_ack = 1'b0;

    // Stall with a taken branch pending, including right after a flush.
    bus.Stall = 1'b1;
    drive(1'b1, 3'b000, 32'd1, 32'd1, 32'h40);
    tick(); check("stall_pc", bus.PC_out, 32'h208);
    check("stall_flush", 32'(bus.Flush), 32'h0);
    bus.Stall = 1'b0;
    drive(1'b1, 3'b000, 32'd1, 32'd1, 32'h10);
    tick(); check("pre_stall_pc", bus.PC_out, 32'h218);
    check("pre_stall_cnt", 32'(bus.Taken_count), 32'h6);
    bus.Stall = 1'b1;
    tick(); check("stall2_pc", bus.PC_out, 32'h218);
    check("stall2_flush", 32'(bus.Flush), 32'h0);
    check("stall2_cnt", 32'(bus.Taken_count), 32'h6);
    bus.Stall = 1'b0;

    // Wraparound of sequential and branch targets.
    drive(1'b1, 3'b000, 32'd0, 32'd0, 32'hFFFF_FDE4);
    tick(); check("to_top_pc", bus.PC_out, 32'hFFFF_FFFC);
    seq_only();
    tick(); check("seq_wrap_pc", bus.PC_out, 32'h0);
    drive(1'b1, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC);
    tick(); check("tgt_wrap_pc", bus.PC_out, 32'hFFFF_FFFC);
    drive(1'b1, 3'b000, 32'd0, 32'd0, 32'h8);
    tick(); check("tgt_wrap2_pc", bus.PC_out, 32'h4);

    // Saturation of the taken counter.
    seq_only();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_cnt", 32'(bus.Taken_count), 32'h0);
    drive(1'b1, 3'b000, 32'd9, 32'd9, 32'h4);
    for (int i = 0; i < 65534; i++) tick();
    check("cnt_fffe", 32'(bus.Taken_count), 32'hFFFE);
    tick(); check("cnt_ffff", 32'(bus.Taken_count), 32'hFFFF);
    tick(); check("cnt_sat", 32'(bus.Taken_count), 32'hFFFF);
    check("cnt_sat_flush", 32'(bus.Flush), 32'h1);
    check("cnt_sat_pc", bus.PC_out, 32'h0004_0000);

    // Reset while trapped.
    drive(1'b1, 3'b001, 32'd1, 32'd0, 32'h6);
    tick(); check("trap2_on", 32'(bus.Trap), 32'h1);
    check("trap2_pc", bus.Trap_pc, 32'h0004_0006);
    bus.Stall = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.Stall = 1'b0;
    seq_only();
    check("rst_trap_pc_out", bus.PC_out, 32'h0);
    check("rst_trap_trap", 32'(bus.Trap), 32'h0);
    check("rst_trap_cnt", 32'(bus.Taken_count), 32'h0);
    check("rst_trap_tpc", bus.Trap_pc, 32'h0);
    tick(); check("post_rst_pc", bus.PC_out, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
